clk_div_ctrl: RTL and testbench

Run-time controller for the programmable clock divider. It accepts new divide ratios over a valid/ready handshake and applies them only at output-period boundaries, so clk_out never produces a runt pulse. It also starts and stops the divided clock glitch-free and emits a one-cycle tick per output period for downstream timers. It sits between the configuration/CSR logic and the divided-clock consumers, all in the clk_in domain.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_core.sv | 46 ++++
 rtl/clk_div_ctrl.sv | 105 ++++++++++
 tb/tb_clk_div_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and limits for the clock divider controller
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter and registered waveform/tick generator
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             run,      // running in the coming cycle
   input  logic [DIV_W-1:0] div,      // divisor in effect in the coming cycle
   output logic             cnt_last, // current cycle is the last of its period
   output logic             clk_out,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_d;
   logic             run_q;

   // Next count: restart at 0 on entry from idle and after each period end.
   always_comb begin
      cnt_d = '0;
      if (run && run_q && !tick) begin
         cnt_d = cnt + DIV_W'(1);
      end
   end

   // Outputs are computed from the next count so they line up with it.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt     <= '0;
         run_q   <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_d;
         run_q   <= run;
         clk_out <= run && (cnt_d >= (div - (div >> 1)));
         tick    <= run && (cnt_d == (div - DIV_W'(1)));
      end
   end

   // The tick already marks the boundary cycle, so the controller reuses it.
   assign cnt_last = tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - divisor handshake, pending register and run/stop FSM
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [DIV_W-1:0] div_active,
   output logic             busy,
   output logic             clk_out,
   output logic             tick
);

   state_t           state;
   state_t           state_d;
   logic [DIV_W-1:0] div_d;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] pend_d;
   logic             err_d;
   logic             cnt_last;
   logic             xfer;
   logic             legal;

   assign cfg_ready = !reset && (state != PEND);
   assign busy      = (state != IDLE);
   assign xfer      = cfg_valid && cfg_ready;
   assign legal     = (cfg_div >= DIV_W'(MIN_DIV));

   // Next state, divisor and pending value; divisor changes only at a period end.
   always_comb begin
      state_d = state;
      div_d   = div_active;
      pend_d  = pend_div;
      err_d   = xfer && !legal;
      case (state)
         IDLE: begin
            if (xfer && legal) begin
               div_d = cfg_div;
            end
            if (enable) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_last) begin
               // A divisor arriving on the boundary itself applies at this wrap.
               if (xfer && legal) begin
                  div_d = cfg_div;
               end
               if (!enable) begin
                  state_d = IDLE;
               end
            end else if (xfer && legal) begin
               pend_d  = cfg_div;
               state_d = PEND;
            end
         end
         PEND: begin
            if (cnt_last) begin
               div_d   = pend_div;
               pend_d  = '0;
               state_d = enable ? RUN : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller registers; reset discards any pending divisor.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state      <= IDLE;
         div_active <= DIV_W'(DEFAULT_DIV);
         pend_div   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_d;
         div_active <= div_d;
         pend_div   <= pend_d;
         cfg_err    <= err_d;
      end
   end

   clk_div_core #(
      .DIV_W (DIV_W)
   ) u_core (
      .clk_in   (clk_in),
      .reset    (reset),
      .run      (state_d != IDLE),
      .div      (div_d),
      .cnt_last (cnt_last),
      .clk_out  (clk_out),
      .tick     (tick)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized self-checking bench against a period-level model
module tb_clk_div_ctrl;

   localparam int DIV_W       = 8;
   localparam int DEFAULT_DIV = 4;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             enable;
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;
   logic [DIV_W-1:0] div_active;
   logic             busy;
   logic             clk_out;
   logic             tick;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: running flag, position inside the period, divisor, optional queued divisor
   bit m_run;
   int m_pos;
   int m_n;
   int m_pend[$];
   bit m_err;
   bit m_rst;

   clk_div_ctrl #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_div    (cfg_div),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .div_active (div_active),
      .busy       (busy),
      .clk_out    (clk_out),
      .tick       (tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit model_ready();
      return !m_rst && (m_pend.size() == 0);
   endfunction

   // One clk_in period of the reference: rules applied to period position and divisor.
   task automatic model_step(input bit en, input bit v, input int d, input bit r);
      bit xfer;
      bit boundary;
      int new_n;
      if (r) begin
         m_run = 0;
         m_pos = 0;
         m_n   = DEFAULT_DIV;
         m_pend.delete();
         m_err = 0;
      end else begin
         xfer     = v && (m_pend.size() == 0);
         boundary = m_run && (m_pos == m_n - 1);
         m_err    = xfer && (d < 2);
         new_n    = m_n;
         if (xfer && d >= 2) begin
            if (!m_run || boundary) new_n = d;
            else m_pend.push_back(d);
         end else if (boundary && m_pend.size() != 0) begin
            new_n = m_pend.pop_front();
         end
         if (!m_run || boundary) begin
            m_run = en;
            m_pos = 0;
         end else begin
            m_pos = m_pos + 1;
         end
         m_n = new_n;
      end
      m_rst = r;
   endtask

   // Check outputs mid-cycle, then drive the next inputs and advance the model.
   task automatic cycle(input bit en, input bit v, input int d, input bit r);
      @(negedge clk_in);
      check("clk_out",    clk_out,    m_run && (m_pos >= m_n - m_n / 2));
      check("tick",       tick,       m_run && (m_pos == m_n - 1));
      check("busy",       busy,       m_run);
      check("div_active", div_active, m_n);
      check("cfg_ready",  cfg_ready,  model_ready());
      check("cfg_err",    cfg_err,    m_err);
      enable    = en;
      cfg_valid = v;
      cfg_div   = DIV_W'(d);
      reset     = r;
      model_step(en, v, d, r);
   endtask

   initial begin
      bit v;
      int d;
      bit en;
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      m_run = 0; m_pos = 0; m_n = DEFAULT_DIV; m_err = 0; m_rst = 1;
      repeat (2) @(posedge clk_in);

      // reset values, then run at the default divisor
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      repeat (12) cycle(1, 0, 0, 0);

      // new divisor 6 mid-period
      for (int k = 0; k < 8 && m_pos != 1; k++) cycle(1, 0, 0, 0);
      cycle(1, 1, 6, 0);
      repeat (16) cycle(1, 0, 0, 0);

      // illegal divisors 1 and 0
      cycle(1, 1, 1, 0);
      cycle(1, 1, 0, 0);
      repeat (6) cycle(1, 0, 0, 0);

      // divisor 5, stop requested at cnt=1, then restart
      cycle(1, 1, 5, 0);
      for (int k = 0; k < 12 && !(m_run && m_n == 5 && m_pos == 1); k++) cycle(1, 0, 0, 0);
      repeat (8) cycle(0, 0, 0, 0);
      repeat (8) cycle(1, 0, 0, 0);

      // reset while a divisor of 8 is pending
      for (int k = 0; k < 8 && m_pos != 1; k++) cycle(1, 0, 0, 0);
      cycle(1, 1, 8, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
      repeat (6) cycle(0, 0, 0, 0);

      // odd divisor loaded together with enable from idle
      cycle(1, 1, 3, 0);
      repeat (9) cycle(1, 0, 0, 0);

      // randomized traffic; cfg_div held while stalled
      v  = 0;
      d  = 0;
      en = 1;
      for (int i = 0; i < 3000; i++) begin
         if (!(v && !model_ready())) begin
            v = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 9);
         end
         if ($urandom_range(0, 39) == 0) en = !en;
         cycle(en, v, d, $urandom_range(0, 199) == 0);
      end
      cycle(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
